// File: rtl/pipeline_hazard_sequencer.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_sequencer
//
// Central stall/flush/redirect controller for the 5-stage MIPS pipeline.
// Branches and jr resolve in ID, so an ID-stage consumer of an in-flight
// producer is held for 1 or 2 cycles. A load feeding the ID comparator needs
// two bubbles; an ALU result in EX or a load in MEM needs one. An ordinary
// load-use into EX needs one. ALU-operand forwarding selects are driven here
// too.
//
// Ports:
//   Clk, Reset           rising-edge clock, synchronous active-high reset
//   IFID_Rs/Rt           source registers of the instruction in ID
//   ID_UsesRt            ID instruction reads rt
//   ID_Branch/BranchCond beq/bne in ID and its resolved condition
//   ID_Jump, ID_JR       j/jal and jr in ID
//   IDEX_*               EX-stage sources, destination, RegWrite, MemRead
//   EXMEM_*              MEM-stage destination, RegWrite, MemRead
//   MEMWB_*              WB-stage destination, RegWrite
//   Ctrl_FwdA/FwdB       0 = register file, 1 = EX/MEM, 2 = MEM/WB
//   Mux_Select_Stall     1 = zero the ID/EX control word (bubble)
//   PCWrite, IFID_Write  pipeline-register write enables
//   IFID_Flush           clear IF/ID on a redirect
//   Ctrl_Branch_Gate, Ctrl_Jump, JRCtrl   next-PC mux selects
//
// Optional feature (macro HAZ_PERF_CNT_EN):
//   stall_cycles[31:0]   cycles with Mux_Select_Stall=1 outside reset
//   redirect_count[31:0] cycles with IFID_Flush=1
// -----------------------------------------------------------------------------
module pipeline_hazard_sequencer #(
    parameter int unsigned REG_W  = 5,
    parameter int unsigned RA_NUM = 31
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [REG_W-1:0] IFID_Rs,
    input  logic [REG_W-1:0] IFID_Rt,
    input  logic             ID_UsesRt,
    input  logic             ID_Branch,
    input  logic             ID_BranchCond,
    input  logic             ID_Jump,
    input  logic             ID_JR,
    input  logic [REG_W-1:0] IDEX_Rs,
    input  logic [REG_W-1:0] IDEX_Rt,
    input  logic             IDEX_RegWrite,
    input  logic             IDEX_MemRead,
    input  logic [REG_W-1:0] IDEX_WriteReg,
    input  logic             EXMEM_RegWrite,
    input  logic             EXMEM_MemRead,
    input  logic [REG_W-1:0] EXMEM_WriteReg,
    input  logic             MEMWB_RegWrite,
    input  logic [REG_W-1:0] MEMWB_WriteReg,
    output logic [1:0]       Ctrl_FwdA,
    output logic [1:0]       Ctrl_FwdB,
    output logic             Mux_Select_Stall,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             Ctrl_Branch_Gate,
    output logic             Ctrl_Jump,
    output logic             JRCtrl
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      redirect_count
`endif
);

    typedef enum logic [0:0] {StRun, StStall} state_e;

    state_e     state_q, state_d;
    logic [1:0] scnt_q, scnt_d;

    // $ra needs no special handling: jal writes it as an ordinary producer.
    logic unused_ra_num;
    assign unused_ra_num = ^RA_NUM;

    // Destination matches against ID-stage sources; $0 never matches.
    logic ex_rs, ex_rt, mem_rs, mem_rt;
    assign ex_rs  = (IDEX_WriteReg  != '0) && (IDEX_WriteReg  == IFID_Rs);
    assign ex_rt  = (IDEX_WriteReg  != '0) && (IDEX_WriteReg  == IFID_Rt);
    assign mem_rs = (EXMEM_WriteReg != '0) && (EXMEM_WriteReg == IFID_Rs);
    assign mem_rt = (EXMEM_WriteReg != '0) && (EXMEM_WriteReg == IFID_Rt);

    // jr only reads rs; a branch compares rs and rt in ID.
    logic id_consumer, ex_rel, mem_rel, load_use, need_two, need_one;
    assign id_consumer = ID_Branch | ID_JR;
    assign ex_rel      = ex_rs  | (ID_Branch & ex_rt);
    assign mem_rel     = mem_rs | (ID_Branch & mem_rt);
    assign load_use    = IDEX_MemRead & (ex_rs | (ID_UsesRt & ex_rt));
    assign need_two    = id_consumer & IDEX_MemRead & ex_rel;
    assign need_one    = load_use
                       | (id_consumer & ((IDEX_RegWrite & ~IDEX_MemRead & ex_rel)
                                         | (EXMEM_MemRead & mem_rel)));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StRun;
            scnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        scnt_d           = scnt_q;
        PCWrite          = 1'b0;
        IFID_Write       = 1'b0;
        Mux_Select_Stall = 1'b1;
        Ctrl_Branch_Gate = 1'b0;
        Ctrl_Jump        = 1'b0;
        JRCtrl           = 1'b0;
        if (!Reset) begin
            unique case (state_q)
                StRun: begin
                    if (need_two) begin
                        // This cycle is the first bubble; STALL supplies the second.
                        state_d = StStall;
                        scnt_d  = 2'd1;
                    end else if (!need_one) begin
                        PCWrite          = 1'b1;
                        IFID_Write       = 1'b1;
                        Mux_Select_Stall = 1'b0;
                        if (ID_JR) begin
                            JRCtrl = 1'b1;
                        end else if (ID_Jump) begin
                            Ctrl_Jump = 1'b1;
                        end else if (ID_Branch && ID_BranchCond) begin
                            Ctrl_Branch_Gate = 1'b1;
                        end
                    end
                end
                StStall: begin
                    // Hazard inputs are ignored while the counter drains.
                    if (scnt_q <= 2'd1) begin
                        state_d = StRun;
                        scnt_d  = 2'd0;
                    end else begin
                        scnt_d = scnt_q - 2'd1;
                    end
                end
                default: begin
                    state_d = StRun;
                    scnt_d  = 2'd0;
                end
            endcase
        end
    end

    assign IFID_Flush = JRCtrl | Ctrl_Jump | Ctrl_Branch_Gate;

    // Operand forwarding into EX: the younger (EX/MEM) producer wins.
    logic exm_a, exm_b, wbm_a, wbm_b;
    assign exm_a = EXMEM_RegWrite && (EXMEM_WriteReg != '0) && (EXMEM_WriteReg == IDEX_Rs);
    assign exm_b = EXMEM_RegWrite && (EXMEM_WriteReg != '0) && (EXMEM_WriteReg == IDEX_Rt);
    assign wbm_a = MEMWB_RegWrite && (MEMWB_WriteReg != '0) && (MEMWB_WriteReg == IDEX_Rs);
    assign wbm_b = MEMWB_RegWrite && (MEMWB_WriteReg != '0) && (MEMWB_WriteReg == IDEX_Rt);

    assign Ctrl_FwdA = Reset ? 2'd0 : exm_a ? 2'd1 : wbm_a ? 2'd2 : 2'd0;
    assign Ctrl_FwdB = Reset ? 2'd0 : exm_b ? 2'd1 : wbm_b ? 2'd2 : 2'd0;

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cycles   <= 32'd0;
            redirect_count <= 32'd0;
        end else begin
            if (Mux_Select_Stall) stall_cycles   <= stall_cycles + 32'd1;
            if (IFID_Flush)       redirect_count <= redirect_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
module tb_pipeline_hazard_sequencer;

    localparam int unsigned REG_W = 5;

    logic             Clk, Reset;
    logic [REG_W-1:0] IFID_Rs, IFID_Rt, IDEX_Rs, IDEX_Rt;
    logic [REG_W-1:0] IDEX_WriteReg, EXMEM_WriteReg, MEMWB_WriteReg;
    logic             ID_UsesRt, ID_Branch, ID_BranchCond, ID_Jump, ID_JR;
    logic             IDEX_RegWrite, IDEX_MemRead, EXMEM_RegWrite, EXMEM_MemRead;
    logic             MEMWB_RegWrite;
    logic [1:0]       Ctrl_FwdA, Ctrl_FwdB;
    logic             Mux_Select_Stall, PCWrite, IFID_Write, IFID_Flush;
    logic             Ctrl_Branch_Gate, Ctrl_Jump, JRCtrl;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0]      stall_cycles, redirect_count;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // {PCWrite, IFID_Write, Mux_Select_Stall, IFID_Flush, Gate, Jump, JR, FwdA, FwdB}
    logic [10:0] obs;
    assign obs = {PCWrite, IFID_Write, Mux_Select_Stall, IFID_Flush,
                  Ctrl_Branch_Gate, Ctrl_Jump, JRCtrl, Ctrl_FwdA, Ctrl_FwdB};

    localparam logic [10:0] OutStall = 11'b001_0000_0000;
    localparam logic [10:0] OutRun   = 11'b110_0000_0000;
    localparam logic [10:0] BitJr    = 11'b000_1001_0000;
    localparam logic [10:0] BitJump  = 11'b000_1010_0000;
    localparam logic [10:0] BitGate  = 11'b000_1100_0000;

    pipeline_hazard_sequencer #(.REG_W(REG_W), .RA_NUM(31)) dut (
        .Clk(Clk), .Reset(Reset),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .ID_UsesRt(ID_UsesRt),
        .ID_Branch(ID_Branch), .ID_BranchCond(ID_BranchCond),
        .ID_Jump(ID_Jump), .ID_JR(ID_JR),
        .IDEX_Rs(IDEX_Rs), .IDEX_Rt(IDEX_Rt),
        .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemRead(IDEX_MemRead),
        .IDEX_WriteReg(IDEX_WriteReg),
        .EXMEM_RegWrite(EXMEM_RegWrite), .EXMEM_MemRead(EXMEM_MemRead),
        .EXMEM_WriteReg(EXMEM_WriteReg),
        .MEMWB_RegWrite(MEMWB_RegWrite), .MEMWB_WriteReg(MEMWB_WriteReg),
        .Ctrl_FwdA(Ctrl_FwdA), .Ctrl_FwdB(Ctrl_FwdB),
        .Mux_Select_Stall(Mux_Select_Stall), .PCWrite(PCWrite),
        .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
        .Ctrl_Branch_Gate(Ctrl_Branch_Gate), .Ctrl_Jump(Ctrl_Jump), .JRCtrl(JRCtrl)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .redirect_count(redirect_count)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic clear_inputs();
        IFID_Rs = '0; IFID_Rt = '0; IDEX_Rs = '0; IDEX_Rt = '0;
        IDEX_WriteReg = '0; EXMEM_WriteReg = '0; MEMWB_WriteReg = '0;
        ID_UsesRt = 0; ID_Branch = 0; ID_BranchCond = 0; ID_Jump = 0; ID_JR = 0;
        IDEX_RegWrite = 0; IDEX_MemRead = 0; EXMEM_RegWrite = 0; EXMEM_MemRead = 0;
        MEMWB_RegWrite = 0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        clear_inputs();
        tick();
        Reset = 1'b0;
    endtask

    // Reference: stall cycles demanded by the current inputs, as the max of
    // every applicable hazard rule.
    function automatic int hazard_n();
        int n = 0;
        logic [REG_W-1:0] srcs [2];
        int nsrc;
        if (IDEX_MemRead && IDEX_WriteReg != 0 &&
            (IDEX_WriteReg == IFID_Rs || (ID_UsesRt && IDEX_WriteReg == IFID_Rt)))
            n = 1;
        if (ID_Branch || ID_JR) begin
            srcs[0] = IFID_Rs;
            srcs[1] = IFID_Rt;
            nsrc = ID_Branch ? 2 : 1;
            for (int k = 0; k < nsrc; k++) begin
                if (srcs[k] != 0) begin
                    if (IDEX_MemRead && IDEX_WriteReg == srcs[k]) n = 2;
                    else if (IDEX_RegWrite && IDEX_WriteReg == srcs[k] && n < 1) n = 1;
                    if (EXMEM_MemRead && EXMEM_WriteReg == srcs[k] && n < 1) n = 1;
                end
            end
        end
        return n;
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [REG_W-1:0] r);
        if (EXMEM_RegWrite && EXMEM_WriteReg != 0 && EXMEM_WriteReg == r) return 2'd1;
        if (MEMWB_RegWrite && MEMWB_WriteReg != 0 && MEMWB_WriteReg == r) return 2'd2;
        return 2'd0;
    endfunction

    task automatic test_reset();
        Reset = 1'b1;
        clear_inputs();
        EXMEM_RegWrite = 1; EXMEM_WriteReg = 5'd4; IDEX_Rs = 5'd4; ID_Jump = 1;
        @(negedge Clk);
        vectors++;
        if (obs !== OutStall) begin
            $display("FAIL reset_outputs: got %b want %b", obs, OutStall);
            miscompares++;
        end
        tick();
        Reset = 1'b0;
        clear_inputs();
        @(negedge Clk);
        vectors++;
        if (obs !== OutRun) begin
            $display("FAIL after_reset_run: got %b want %b", obs, OutRun);
            miscompares++;
        end
    endtask

    task automatic test_load_use();
        do_reset();
        IDEX_MemRead = 1; IDEX_RegWrite = 1; IDEX_WriteReg = 5'd2; IFID_Rs = 5'd2;
        @(negedge Clk);
        vectors++;
        if (obs !== OutStall) begin
            $display("FAIL load_use_stall: got %b want %b", obs, OutStall);
            miscompares++;
        end
        tick();
        IDEX_MemRead = 0; IDEX_RegWrite = 0;
        @(negedge Clk);
        vectors++;
        if (obs !== OutRun) begin
            $display("FAIL load_use_release: got %b want %b", obs, OutRun);
            miscompares++;
        end
        tick();
        // rt match ignored when the instruction does not read rt
        IDEX_MemRead = 1; IDEX_WriteReg = 5'd3; IFID_Rs = 5'd0; IFID_Rt = 5'd3;
        ID_UsesRt = 0;
        @(negedge Clk);
        vectors++;
        if (obs !== OutRun) begin
            $display("FAIL load_use_rt_unused: got %b want %b", obs, OutRun);
            miscompares++;
        end
    endtask

    task automatic test_branch_load();
        do_reset();
        IDEX_MemRead = 1; IDEX_RegWrite = 1; IDEX_WriteReg = 5'd8;
        IFID_Rs = 5'd8; IFID_Rt = 5'd9; ID_UsesRt = 1;
        ID_Branch = 1; ID_BranchCond = 1;
        @(negedge Clk);
        vectors++;
        if (obs !== OutStall) begin
            $display("FAIL branch_load_stall1: got %b want %b", obs, OutStall);
            miscompares++;
        end
        tick();  // hazard inputs held: second bubble must not re-arm
        @(negedge Clk);
        vectors++;
        if (obs !== OutStall) begin
            $display("FAIL branch_load_stall2: got %b want %b", obs, OutStall);
            miscompares++;
        end
        tick();
        IDEX_MemRead = 0; IDEX_RegWrite = 0; IDEX_WriteReg = 5'd0;
        @(negedge Clk);
        vectors++;
        if (obs !== (OutRun | BitGate)) begin
            $display("FAIL branch_taken: got %b want %b", obs, OutRun | BitGate);
            miscompares++;
        end
    endtask

    task automatic test_jr();
        do_reset();
        IDEX_RegWrite = 1; IDEX_WriteReg = 5'd31; IFID_Rs = 5'd31;
        ID_JR = 1; ID_Jump = 1;
        @(negedge Clk);
        vectors++;
        if (obs !== OutStall) begin
            $display("FAIL jr_stall: got %b want %b", obs, OutStall);
            miscompares++;
        end
        tick();
        IDEX_RegWrite = 0;
        @(negedge Clk);
        vectors++;
        if (obs !== (OutRun | BitJr)) begin
            $display("FAIL jr_redirect: got %b want %b", obs, OutRun | BitJr);
            miscompares++;
        end
        tick();
        ID_JR = 0;
        @(negedge Clk);
        vectors++;
        if (obs !== (OutRun | BitJump)) begin
            $display("FAIL jump_no_stall: got %b want %b", obs, OutRun | BitJump);
            miscompares++;
        end
    endtask

    task automatic test_forwarding();
        do_reset();
        EXMEM_RegWrite = 1; EXMEM_WriteReg = 5'd4;
        MEMWB_RegWrite = 1; MEMWB_WriteReg = 5'd4;
        IDEX_Rs = 5'd4; IDEX_Rt = 5'd0;
        @(negedge Clk);
        vectors++;
        if (obs !== (OutRun | 11'b0100)) begin
            $display("FAIL fwd_exmem: got %b want %b", obs, OutRun | 11'b0100);
            miscompares++;
        end
        EXMEM_RegWrite = 0; IDEX_Rt = 5'd4;
        @(posedge Clk);
        @(negedge Clk);
        vectors++;
        if (obs !== (OutRun | 11'b1010)) begin
            $display("FAIL fwd_memwb: got %b want %b", obs, OutRun | 11'b1010);
            miscompares++;
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        IDEX_RegWrite = 1; IDEX_MemRead = 1; EXMEM_RegWrite = 1; EXMEM_MemRead = 1;
        MEMWB_RegWrite = 1; ID_UsesRt = 1; ID_Branch = 1; ID_JR = 0;
        @(negedge Clk);
        vectors++;
        if (obs !== OutRun) begin
            $display("FAIL zero_reg: got %b want %b", obs, OutRun);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        IDEX_MemRead = 1; IDEX_WriteReg = 5'd8; IFID_Rs = 5'd8;
        ID_Branch = 1; ID_BranchCond = 0;
        tick();  // now in the second bubble
        Reset = 1'b1;
        clear_inputs();
        @(negedge Clk);
        vectors++;
        if (obs !== OutStall) begin
            $display("FAIL mid_stall_reset: got %b want %b", obs, OutStall);
            miscompares++;
        end
        tick();
        Reset = 1'b0;
        @(negedge Clk);
        vectors++;
        if (obs !== OutRun) begin
            $display("FAIL mid_stall_resume: got %b want %b", obs, OutRun);
            miscompares++;
        end
`ifdef HAZ_PERF_CNT_EN
        vectors++;
        if (stall_cycles !== 32'd0 || redirect_count !== 32'd0) begin
            $display("FAIL perf_cleared: got %0d/%0d want 0/0", stall_cycles, redirect_count);
            miscompares++;
        end
`endif
    endtask

    task automatic test_random();
        int          stall_left = 0;
        int          n;
        logic [10:0] exp;
        logic [31:0] m_stall = 0, m_redir = 0;
        for (int i = 0; i < 600; i++) begin
            Reset          = (i == 0) || ($urandom_range(0, 24) == 0);
            IFID_Rs        = 5'($urandom_range(0, 3));
            IFID_Rt        = 5'($urandom_range(0, 3));
            IDEX_Rs        = 5'($urandom_range(0, 3));
            IDEX_Rt        = 5'($urandom_range(0, 3));
            IDEX_WriteReg  = 5'($urandom_range(0, 3));
            EXMEM_WriteReg = 5'($urandom_range(0, 3));
            MEMWB_WriteReg = 5'($urandom_range(0, 3));
            ID_UsesRt      = 1'($urandom_range(0, 1));
            ID_Branch      = 1'($urandom_range(0, 1));
            ID_BranchCond  = 1'($urandom_range(0, 1));
            ID_Jump        = ($urandom_range(0, 3) == 0);
            ID_JR          = ($urandom_range(0, 3) == 0);
            IDEX_RegWrite  = 1'($urandom_range(0, 1));
            IDEX_MemRead   = ($urandom_range(0, 2) == 0);
            EXMEM_RegWrite = 1'($urandom_range(0, 1));
            EXMEM_MemRead  = ($urandom_range(0, 2) == 0);
            MEMWB_RegWrite = 1'($urandom_range(0, 1));
            @(negedge Clk);
            n   = hazard_n();
            exp = '0;
            if (Reset) begin
                exp = OutStall;
            end else begin
                exp[3:2] = ref_fwd(IDEX_Rs);
                exp[1:0] = ref_fwd(IDEX_Rt);
                if (stall_left > 0 || n > 0) begin
                    exp[8] = 1'b1;
                end else begin
                    exp[10:9] = 2'b11;
                    if (ID_JR) exp[4] = 1'b1;
                    else if (ID_Jump) exp[5] = 1'b1;
                    else if (ID_Branch && ID_BranchCond) exp[6] = 1'b1;
                    exp[7] = exp[4] | exp[5] | exp[6];
                end
            end
            vectors++;
            if (obs !== exp) begin
                $display("FAIL random[%0d]: got %b want %b", i, obs, exp);
                miscompares++;
            end
`ifdef HAZ_PERF_CNT_EN
            vectors++;
            if (stall_cycles !== m_stall || redirect_count !== m_redir) begin
                $display("FAIL random_perf[%0d]: got %0d/%0d want %0d/%0d",
                         i, stall_cycles, redirect_count, m_stall, m_redir);
                miscompares++;
            end
`endif
            if (Reset) begin
                stall_left = 0;
                m_stall    = 0;
                m_redir    = 0;
            end else begin
                if (stall_left > 0) stall_left--;
                else if (n > 0) stall_left = n - 1;
                if (exp[8]) m_stall++;
                if (exp[7]) m_redir++;
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_load();
        test_jr();
        test_forwarding();
        test_zero_reg();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_sequencer.md
Name: pipeline_hazard_sequencer

Overview:
Central stall/flush/redirect controller for the 5-stage MIPS pipeline. Drives the forwarding selects of the two ALU source muxes, the select line of the hazard stall mux, the three next-PC muxes (branch gate, jump, jr), and the PC and IF/ID write enables. Branches and jr resolve in ID. An internal FSM sequences stalls of 1 or 2 cycles when an ID-stage consumer depends on an in-flight producer.

Parameters:
REG_W, 5, register address width
RA_NUM, 31, $ra index; a jal destination is treated as a normal producer

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high
IFID_Rs  in  REG_W  rs of the instruction in ID
IFID_Rt  in  REG_W  rt of the instruction in ID
ID_UsesRt  in  1  ID instruction reads rt (R-type, beq/bne, sw)
ID_Branch  in  1  ID instruction is beq/bne
ID_BranchCond  in  1  branch condition true (comparator in ID)
ID_Jump  in  1  j/jal in ID
ID_JR  in  1  jr in ID
IDEX_Rs, IDEX_Rt  in  REG_W  EX-stage source registers
IDEX_RegWrite, IDEX_MemRead  in  1  EX-stage control
IDEX_WriteReg  in  REG_W  EX destination after RegDst mux
EXMEM_RegWrite, EXMEM_MemRead  in  1  MEM-stage control
EXMEM_WriteReg  in  REG_W  MEM destination
MEMWB_RegWrite  in  1  WB-stage control
MEMWB_WriteReg  in  REG_W  WB destination
Ctrl_FwdA, Ctrl_FwdB  out  2  0 = register file, 1 = EX/MEM, 2 = MEM/WB
Mux_Select_Stall  out  1  1 = zero ID/EX control (bubble)
PCWrite, IFID_Write  out  1  pipeline-register write enables
IFID_Flush  out  1  clear IF/ID on redirect
Ctrl_Branch_Gate, Ctrl_Jump, JRCtrl  out  1  next-PC mux selects

Behaviour:
- Clock and reset: a single clock (Clk). Reset is synchronous and active-high.
- State encoding: FSM with states RUN and STALL, plus a 2-bit stall counter scnt. On Reset: state=RUN, scnt=0.
- Reset-cycle outputs: while Reset=1, outputs are forced to PCWrite=0, IFID_Write=0, Mux_Select_Stall=1, IFID_Flush=0, all redirects 0, FwdA=FwdB=0.
- Match rule: a match requires the producer's RegWrite=1 (or MemRead=1 where stated) and a destination that is nonzero and equal to the consumer register.
- Load-use, needs 1 stall: IDEX_MemRead with IDEX_WriteReg == IFID_Rs, or == IFID_Rt with ID_UsesRt.
- ID consumer (ID_Branch or ID_JR), needs 2 stalls: load in EX on the relevant reg. For jr, only rs is relevant; for a branch, rs and rt are relevant.
- ID consumer, needs 1 stall: IDEX_RegWrite non-load match, or EXMEM_MemRead match.
- Stall count: N = max over all applicable hazards. N=0 means no hazard.
- RUN state, N≥1 this cycle:
  - outputs PCWrite=0, IFID_Write=0, Mux_Select_Stall=1, all redirects 0, IFID_Flush=0;
  - if N=2, go to STALL with scnt=1; if N=1, stay in RUN.
- STALL state: the same stall outputs; hazard inputs are ignored; scnt decrements. At scnt=0 → RUN, where hazards are re-evaluated.
- RUN state, N=0: PCWrite=IFID_Write=1, Mux_Select_Stall=0, then redirect priority:
  - ID_JR: JRCtrl=1;
  - else ID_Jump: Ctrl_Jump=1;
  - else ID_Branch & ID_BranchCond: Ctrl_Branch_Gate=1.
  - IFID_Flush=1 whenever any redirect is 1 in that cycle.
- ID_Jump never stalls: it has no register source.
- Forwarding is combinational and state-independent:
  - FwdA=1 if EXMEM_RegWrite & EXMEM_WriteReg≠0 & ==IDEX_Rs;
  - else FwdA=2 on the same test against MEMWB;
  - else 0.
  - FwdB is identical using IDEX_Rt.
  - Value 3 is never driven.
- Redirect and stall outputs are combinational from state and inputs. Only state and scnt are registered. Latency from a hazard to its stall outputs is 0 cycles.
- Reset mid-STALL: the next state is RUN with scnt=0; any remaining stall cycles are abandoned.

Optional Feature:
HAZ_PERF_CNT_EN:
- Defined: adds outputs stall_cycles[31:0] and redirect_count[31:0]. These are synchronously cleared by Reset. stall_cycles increments on every cycle with Mux_Select_Stall=1 and Reset=0. redirect_count increments on every IFID_Flush=1. Both wrap at 2^32 silently.
- Undefined: the ports and logic are absent.

Test Plan:
- lw $2 in EX (IDEX_MemRead=1, IDEX_WriteReg=2), add reading rs=2 in ID → one cycle with PCWrite=0, IFID_Write=0, Mux_Select_Stall=1; next cycle (IDEX_MemRead=0) normal flow.
- lw $8 in EX, beq $8,$9 in ID with ID_BranchCond=1 → 2 stall cycles (FSM passes through STALL), then Ctrl_Branch_Gate=1, IFID_Flush=1 in the third cycle.
- addi $31 in EX (RegWrite, WriteReg=31), jr $31 in ID → 1 stall, then JRCtrl=1, IFID_Flush=1; a simultaneous ID_Jump=1 still yields Ctrl_Jump=0.
- EXMEM writes $4, MEMWB writes $4, IDEX_Rs=4, IDEX_Rt=0 → FwdA=1, FwdB=0. With EXMEM_RegWrite=0 → FwdA=2.
- Writes to $0 from every stage, IFID_Rs=0 → no stall, FwdA=FwdB=0.
- Reset asserted in the STALL cycle of a 2-stall sequence → next cycle RUN, PCWrite=1 with no hazard; with HAZ_PERF_CNT_EN defined, stall_cycles=0 after reset.
